// File: rtl/ir_queue.sv
// ir_queue: LC-3 instruction register fronted by a DEPTH-entry prefetch FIFO.
// Fetched words are buffered in order, issued through a valid/ready handshake,
// and the head word is decoded into LC-3 fields and sign-extended offsets.
// A flush discards everything queued (taken branch, JSR or trap redirect).
// Optional feature macro: IR_BYPASS_EN. When defined, an empty queue forwards
// in_data straight to the decode outputs in the same cycle.
module ir_queue #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            raw,
  output logic [3:0]                   opcode,
  output logic [2:0]                   dest,
  output logic [2:0]                   src1,
  output logic [2:0]                   src2,
  output logic                         imm5_sel,
  output logic                         jsr_sel,
  output logic [11:0]                  ledVect12,
  output logic [WORD_W-1:0]            sext5,
  output logic [WORD_W-1:0]            sext6,
  output logic [WORD_W-1:0]            sext9,
  output logic [WORD_W-1:0]            sext11,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;

  logic              empty;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] head_src;
  logic [WORD_W-1:0] head;

  assign empty    = (occ == '0);
  assign in_ready = (occ != CNT_W'(DEPTH));
  assign count    = occ;

  // Head source selection: stored head, or the incoming word when bypassing an empty queue
`ifdef IR_BYPASS_EN
  always_comb begin
    head_src  = mem[rd_ptr];
    out_valid = !empty;
    if (empty && !flush) begin
      head_src  = in_data;
      out_valid = in_valid;
    end
  end
`else
  always_comb begin
    head_src  = mem[rd_ptr];
    out_valid = !empty;
  end
`endif

  // Handshakes; a pop while empty can only be a bypassed word, which is never stored
  always_comb begin
    push  = in_valid & in_ready;
    pop   = out_valid & out_ready;
    rd_en = pop & !empty;
    wr_en = push & !(pop & empty);
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage array; contents are never cleared, only the pointers are
  always_ff @(posedge clk) begin
    if (wr_en && !reset && !flush) mem[wr_ptr] <= in_data;
  end

  // LC-3 field decode of the head word, forced to zero when nothing is valid
  always_comb begin
    head      = out_valid ? head_src : '0;
    raw       = head;
    opcode    = head[15:12];
    dest      = head[11:9];
    src1      = head[8:6];
    src2      = head[2:0];
    imm5_sel  = head[5];
    jsr_sel   = head[11];
    ledVect12 = head[11:0];
    sext5     = {{(WORD_W-5){head[4]}},   head[4:0]};
    sext6     = {{(WORD_W-6){head[5]}},   head[5:0]};
    sext9     = {{(WORD_W-9){head[8]}},   head[8:0]};
    sext11    = {{(WORD_W-11){head[10]}}, head[10:0]};
  end

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ir_queue;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);
`ifdef IR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  raw;
  logic [3:0]    opcode;
  logic [2:0]    dest, src1, src2;
  logic          imm5_sel, jsr_sel;
  logic [11:0]   ledVect12;
  logic [W-1:0]  sext5, sext6, sext9, sext11;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] model_q[$];

  ir_queue #(.WORD_W(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .raw(raw), .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .imm5_sel(imm5_sel), .jsr_sel(jsr_sel), .ledVect12(ledVect12),
    .sext5(sext5), .sext6(sext6), .sext9(sext9), .sext11(sext11), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Two's-complement value of the low k bits, re-expressed modulo 2^W
  function automatic logic [W-1:0] sx(input int k, input logic [W-1:0] r);
    longint v;
    v = longint'(r) % (64'sd1 <<< k);
    if (v >= (64'sd1 <<< (k - 1))) v = v - (64'sd1 <<< k);
    return W'(v);
  endfunction

  // Reference model: the queue contents after each clock edge
  always @(posedge clk) begin
    bit bypass, push, pop;
    if (reset || flush) begin
      model_q.delete();
    end else begin
      bypass = BYP && model_q.size() == 0 && in_valid;
      push   = in_valid && model_q.size() < D;
      pop    = out_ready && (model_q.size() > 0 || bypass);
      if (!(bypass && out_ready)) begin
        if (pop)  void'(model_q.pop_front());
        if (push) model_q.push_back(in_data);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic          ev;
    logic [W-1:0]  h;
    if (chk_en && !reset) begin
      ev = (model_q.size() > 0) || (BYP && !flush && in_valid);
      h  = (model_q.size() > 0) ? model_q[0] : (ev ? in_data : '0);
      chk("m_out_valid", 64'(out_valid), 64'(ev));
      chk("m_in_ready",  64'(in_ready),  64'(model_q.size() < D));
      chk("m_count",     64'(count),     64'(model_q.size()));
      chk("m_raw",       64'(raw),       64'(h));
      chk("m_opcode",    64'(opcode),    64'((h >> 12) & 16'hF));
      chk("m_dest",      64'(dest),      64'((h >> 9) & 16'h7));
      chk("m_src1",      64'(src1),      64'((h >> 6) & 16'h7));
      chk("m_src2",      64'(src2),      64'(h & 16'h7));
      chk("m_imm5_sel",  64'(imm5_sel),  64'((h >> 5) & 16'h1));
      chk("m_jsr_sel",   64'(jsr_sel),   64'((h >> 11) & 16'h1));
      chk("m_ledVect12", 64'(ledVect12), 64'(h & 16'hFFF));
      chk("m_sext5",     64'(sext5),     64'(sx(5, h)));
      chk("m_sext6",     64'(sext6),     64'(sx(6, h)));
      chk("m_sext9",     64'(sext9),     64'(sx(9, h)));
      chk("m_sext11",    64'(sext11),    64'(sx(11, h)));
    end
  end

  // Drive one cycle's inputs, let the edge happen, then return to idle inputs
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;

    // 1) reset state, then ADD R1,R1,#1
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_raw", 64'(raw), 64'd0);
    cyc(1'b1, 16'h1261, 1'b0, 1'b0);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_opcode", 64'(opcode), 64'd1);
    chk("t1_dest", 64'(dest), 64'd1);
    chk("t1_src1", 64'(src1), 64'd1);
    chk("t1_imm5_sel", 64'(imm5_sel), 64'd1);
    chk("t1_sext5", 64'(sext5), 64'h0001);
    chk("t1_count", 64'(count), 64'd1);

    // 2) BRnzp -8 and a JSR with offset -1
    cyc(1'b1, 16'h0FF8, 1'b1, 1'b0);
    chk("t2_raw_br", 64'(raw), 64'h0FF8);
    chk("t2_sext9", 64'(sext9), 64'hFFF8);
    chk("t2_dest", 64'(dest), 64'd7);
    cyc(1'b1, 16'h4FFF, 1'b1, 1'b0);
    chk("t2_jsr_sel", 64'(jsr_sel), 64'd1);
    chk("t2_sext11", 64'(sext11), 64'hFFFF);
    chk("t2_count", 64'(count), 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t2_drained", 64'(count), 64'd0);

    // 3) fill to DEPTH, overflow attempt ignored, drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    chk("t3_full_count", 64'(count), 64'd4);
    chk("t3_full_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("t3_ovf_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 64'(raw), 64'(16'hA000 + 16'(i)));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t3_empty_count", 64'(count), 64'd0);
    chk("t3_empty_valid", 64'(out_valid), 64'd0);
    chk("t3_empty_raw", 64'(raw), 64'd0);

    // 4) steady push+pop at count==3 with pointer wrap
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("t4_order", 64'(raw), 64'(16'h3000 + 16'(k)));
      cyc(1'b1, 16'h3000 + 16'(k + 3), 1'b1, 1'b0);
      chk("t4_count", 64'(count), 64'd3);
    end

    // 5) flush at count==2 with simultaneous push and pop
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5_pre_count", 64'(count), 64'd2);
    cyc(1'b1, 16'h5555, 1'b1, 1'b1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_raw", 64'(raw), 64'd0);
    chk("t5_sext9", 64'(sext9), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t5_discarded", 64'(count), 64'd0);

    // 6) empty queue, word offered with decode ready
    in_valid = 1'b1; in_data = 16'hE005; out_ready = 1'b1; flush = 1'b0;
    #1;
    chk("t6_same_valid", 64'(out_valid), BYP ? 64'd1 : 64'd0);
    chk("t6_same_opcode", 64'(opcode), BYP ? 64'hE : 64'd0);
    chk("t6_same_sext9", 64'(sext9), BYP ? 64'h0005 : 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("t6_next_count", 64'(count), BYP ? 64'd0 : 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t6_clear", 64'(count), 64'd0);

    // bypass-capable empty queue with decode stalled: word must be stored
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    #1;
    chk("t6b_same_valid", 64'(out_valid), BYP ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    #1;
    chk("t6b_count", 64'(count), 64'd1);
    chk("t6b_raw", 64'(raw), 64'h1234);

    // reset overrides a concurrent push
    reset = 1'b1;
    cyc(1'b1, 16'h7777, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("t7_rst_count", 64'(count), 64'd0);
    chk("t7_rst_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
